exc_pipe_ctrl: RTL and testbench
================================

EXC_PIPE_CTRL -- requirements
Module: exc_pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 3; number of tracked pipeline stages (stage 0 = D, stage NSTAGE-1 = commit stage M).
REQ-002 SHALL have parameter NSRC, default 4; exception sources per stage.
REQ-003 SHALL have parameter ADDR_W, default 32; PC width.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  in  1  instruction entering stage 0.
REQ-007 SHALL have port in_pc  in  ADDR_W  PC of the entering instruction.
REQ-008 SHALL have port in_bd  in  1  entering instruction sits in a branch delay slot.
REQ-009 SHALL have port src_hit  in  NSTAGE*NSRC  exception flags; stage s, source k at bit s*NSRC+k.
REQ-010 SHALL have port src_code  in  NSTAGE*NSRC*5  ExcCode per source, same ordering.
REQ-011 SHALL have port stall  in  NSTAGE  per-stage hold; stall[s]=1 implies stall[0..s-1]=1.
REQ-012 SHALL have port int_req  in  1  pending external interrupt, level.
REQ-013 SHALL have port eret  in  1  eret is in the commit stage.
REQ-014 SHALL have port exc_req  out  1  exception taken this cycle.
REQ-015 SHALL have port exc_cause  out  32  {BD, 24'b0, ExcCode[4:0], 2'b0}.
REQ-016 SHALL have port exc_epc  out  ADDR_W  restart PC.
REQ-017 SHALL have port flush  out  1  kill all younger stages, both on exceptions and on eret.

Function
REQ-018 SHALL hold per stage one record: valid, pc, bd, exc, code.
REQ-019 SHALL load record 0 from in_* on each edge where stall[0]=0.
REQ-020 SHALL move record s into s+1 on each edge where stall[s+1]=0, merging stage-s sources first.
REQ-021 SHALL load a bubble (valid=0) into s+1 when stall[s]=1 and stall[s+1]=0.
REQ-022 SHALL apply this merge priority: an exc already set in the record is kept; otherwise the lowest-index asserted src_hit of that stage sets exc and its code.
REQ-023 SHALL ignore src_hit for stages whose record has valid=0.
REQ-024 SHALL drive exc_req combinationally as record[NSTAGE-1].valid & (merged exc | int_req).
REQ-025 SHALL treat interrupts as lowest priority, using code 0; a bubble in the commit stage defers the interrupt.
REQ-026 SHALL drive exc_epc as pc-4 when bd=1 and as pc otherwise; exc_cause[31]=bd.
REQ-027 SHALL assert flush when exc_req | (eret & record[NSTAGE-1].valid).
REQ-028 SHALL let exc_req win when it coincides with eret, with flush asserted.
REQ-029 SHALL clear every record's valid on the edge after flush, overriding stall; the stage-0 load is suppressed that edge.
REQ-030 SHALL produce exc_req exactly NSTAGE-1-s cycles after a stage-s hit when there are no stalls, and exactly one cycle per excepting instruction.
REQ-031 SHALL drive exc_cause and exc_epc to 0 when exc_req=0.

Reset
REQ-032 SHALL, while reset=0, immediately clear all records (valid=0, exc=0, code=0, pc=0, bd=0); exc_req, flush, exc_cause and exc_epc then read 0.
REQ-033 SHALL accept in_valid on the first rising edge after reset deasserts.

Structure
REQ-034 SHALL place ExcCode constants in package exc_pkg: INT=0, ADEL=4, ADES=5, RI=10, OV=12. The package also holds CAUSE_BD_BIT=31 and CODE_LSB=2.
REQ-035 SHALL implement one record plus its merge in sub-module exc_stage_rec, generated NSTAGE times.

Verification
REQ-036 SHALL cover: pc=0x3000 enters with stage0 src1 code 10, no stalls -> exc_req at cycle+2, exc_cause=0x00000028, exc_epc=0x3000, flush.
REQ-037 SHALL cover: stage0 code 4 and stage1 code 12 on the same instruction -> exc_cause code 4 only.
REQ-038 SHALL cover: bd=1, pc=0x3008, stage2 code 12 -> exc_cause=0x80000030, exc_epc=0x3004.
REQ-039 SHALL cover: int_req with a commit-stage bubble for 2 cycles -> no exc_req until a valid record arrives, then code 0.
REQ-040 SHALL cover: stall=3'b011 for 3 cycles with an excepting instruction in stage 1 -> bubbles enter stage 2, exc_req delayed 3 cycles, single pulse.
REQ-041 SHALL cover: reset pulled low mid-flight with 3 valid records -> all outputs 0 immediately, no exc_req after release.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared exception definitions for the pipeline exception controller:
// ExcCode values, cause-register layout and the per-stage tag record.
package exc_pkg;

  localparam int unsigned CODE_W       = 5;
  localparam int unsigned CAUSE_W      = 32;
  localparam int unsigned CAUSE_BD_BIT = 31;
  localparam int unsigned CODE_LSB     = 2;

  localparam logic [CODE_W-1:0] INT  = 5'd0;
  localparam logic [CODE_W-1:0] ADEL = 5'd4;
  localparam logic [CODE_W-1:0] ADES = 5'd5;
  localparam logic [CODE_W-1:0] RI   = 5'd10;
  localparam logic [CODE_W-1:0] OV   = 5'd12;

  // Control part of one stage record; the PC travels alongside it.
  typedef struct packed {
    logic              valid;
    logic              bd;
    logic              exc;
    logic [CODE_W-1:0] code;
  } exc_tag_t;

  // Cause register image: {BD, zeros, ExcCode, 2'b0}.
  function automatic logic [CAUSE_W-1:0] cause_word(input logic bd,
                                                    input logic [CODE_W-1:0] code);
    logic [CAUSE_W-1:0] w;
    w                     = '0;
    w[CAUSE_BD_BIT]       = bd;
    w[CODE_LSB +: CODE_W] = code;
    return w;
  endfunction

endpackage

// File: rtl/exc_stage_rec.sv
// One pipeline-stage exception record plus the merge of that stage's
// exception sources into the record as it leaves the stage.
module exc_stage_rec
  import exc_pkg::*;
#(
  parameter int unsigned NSRC   = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  exc_tag_t               tag_i,
  input  logic [ADDR_W-1:0]      pc_i,
  input  logic [NSRC-1:0]        hit_i,
  input  logic [NSRC*CODE_W-1:0] code_i,
  output exc_tag_t               tag_merged_o,
  output logic [ADDR_W-1:0]      pc_o
);

  exc_tag_t          tag_q, tag_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  // Flush beats load and hold; a flushed record becomes a clean bubble.
  always_comb begin
    tag_d = tag_q;
    pc_d  = pc_q;
    if (flush_i) begin
      tag_d = '0;
    end else if (load_i) begin
      tag_d = tag_i;
      pc_d  = pc_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
      pc_q  <= '0;
    end else begin
      tag_q <= tag_d;
      pc_q  <= pc_d;
    end
  end

  // Older exception wins; otherwise the lowest-index hit of a valid record.
  always_comb begin
    tag_merged_o = tag_q;
    if (tag_q.valid && !tag_q.exc) begin
      for (int k = int'(NSRC) - 1; k >= 0; k--) begin
        if (hit_i[k]) begin
          tag_merged_o.exc  = 1'b1;
          tag_merged_o.code = code_i[k*CODE_W +: CODE_W];
        end
      end
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/exc_pipe_ctrl.sv
// Precise-exception controller: tracks one record per pipeline stage and
// raises exception / flush at the commit stage.
module exc_pipe_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned NSTAGE = 3,
  parameter int unsigned NSRC   = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [ADDR_W-1:0]             in_pc,
  input  logic                          in_bd,
  input  logic [NSTAGE*NSRC-1:0]        src_hit,
  input  logic [NSTAGE*NSRC*CODE_W-1:0] src_code,
  input  logic [NSTAGE-1:0]             stall,
  input  logic                          int_req,
  input  logic                          eret,
  output logic                          exc_req,
  output logic [CAUSE_W-1:0]            exc_cause,
  output logic [ADDR_W-1:0]             exc_epc,
  output logic                          flush
);

  localparam int unsigned LAST = NSTAGE - 1;

  exc_tag_t          up_tag [NSTAGE];
  exc_tag_t          tag_m  [NSTAGE];
  logic [ADDR_W-1:0] up_pc  [NSTAGE];
  logic [ADDR_W-1:0] pc_q   [NSTAGE];

  for (genvar s = 0; s < NSTAGE; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign up_tag[s] = '{valid: in_valid, bd: in_bd, exc: 1'b0, code: INT};
      assign up_pc[s]  = in_pc;
    end else begin : g_body
      // A stalled upstream stage hands a bubble to a moving downstream stage.
      assign up_tag[s] = stall[s-1] ? exc_tag_t'('0) : tag_m[s-1];
      assign up_pc[s]  = stall[s-1] ? '0 : pc_q[s-1];
    end

    exc_stage_rec #(
      .NSRC   (NSRC),
      .ADDR_W (ADDR_W)
    ) u_rec (
      .clk_i        (clk),
      .rst_ni       (reset),
      .flush_i      (flush),
      .load_i       (~stall[s]),
      .tag_i        (up_tag[s]),
      .pc_i         (up_pc[s]),
      .hit_i        (src_hit[s*NSRC +: NSRC]),
      .code_i       (src_code[s*NSRC*CODE_W +: NSRC*CODE_W]),
      .tag_merged_o (tag_m[s]),
      .pc_o         (pc_q[s])
    );
  end

  exc_tag_t          commit_tag;
  logic [ADDR_W-1:0] commit_pc;

  // Commit-stage decision; interrupts only ride on a valid record, code 0.
  always_comb begin
    commit_tag = tag_m[LAST];
    commit_pc  = pc_q[LAST];
    exc_req    = commit_tag.valid & (commit_tag.exc | int_req);
    flush      = exc_req | (eret & commit_tag.valid);
    exc_cause  = '0;
    exc_epc    = '0;
    if (exc_req) begin
      exc_cause = cause_word(commit_tag.bd, commit_tag.exc ? commit_tag.code : INT);
      exc_epc   = commit_tag.bd ? commit_pc - ADDR_W'(4) : commit_pc;
    end
  end

endmodule

// File: tb/tb_exc_pipe_ctrl.sv
// Scoreboard bench for exc_pipe_ctrl: expected exceptions are queued when
// stimulus is driven and matched against exc_req pulses at the commit stage.
module tb_exc_pipe_ctrl;
  import exc_pkg::*;

  localparam int unsigned NSTAGE = 3;
  localparam int unsigned NSRC   = 4;
  localparam int unsigned ADDR_W = 32;

  logic                          clk      = 1'b0;
  logic                          reset    = 1'b1;
  logic                          in_valid = 1'b0;
  logic [ADDR_W-1:0]             in_pc    = '0;
  logic                          in_bd    = 1'b0;
  logic [NSTAGE*NSRC-1:0]        src_hit  = '0;
  logic [NSTAGE*NSRC*CODE_W-1:0] src_code = '0;
  logic [NSTAGE-1:0]             stall    = '0;
  logic                          int_req  = 1'b0;
  logic                          eret     = 1'b0;
  logic                          exc_req;
  logic [CAUSE_W-1:0]            exc_cause;
  logic [ADDR_W-1:0]             exc_epc;
  logic                          flush;

  typedef struct {
    int          at;
    logic [31:0] cause;
    logic [31:0] epc;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;
  int   t;

  exc_pipe_ctrl #(.NSTAGE(NSTAGE), .NSRC(NSRC), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_bd     (in_bd),
    .src_hit   (src_hit),
    .src_code  (src_code),
    .stall     (stall),
    .int_req   (int_req),
    .eret      (eret),
    .exc_req   (exc_req),
    .exc_cause (exc_cause),
    .exc_epc   (exc_epc),
    .flush     (flush)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    in_valid = 1'b0;
    in_bd    = 1'b0;
    in_pc    = '0;
    src_hit  = '0;
    src_code = '0;
    stall    = '0;
    int_req  = 1'b0;
    eret     = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      clr();
      tick();
    end
  endtask

  task automatic issue(input logic [31:0] pc, input logic bd);
    in_valid = 1'b1;
    in_pc    = pc;
    in_bd    = bd;
  endtask

  task automatic set_hit(input int s, input int k, input logic [4:0] c);
    src_hit[s*NSRC+k]                  = 1'b1;
    src_code[(s*NSRC+k)*CODE_W +: CODE_W] = c;
  endtask

  task automatic expect_exc(input int at, input logic [31:0] cause, input logic [31:0] epc);
    exp_t e;
    e.at = at; e.cause = cause; e.epc = epc;
    sb.push_back(e);
  endtask

  // Commit-stage monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (exc_req) begin
        if (sb.size() == 0) begin
          check_val("spurious_exc_req", 64'(exc_req), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("exc_cycle", 64'(cyc), 64'(e.at));
          check_val("exc_cause", 64'(exc_cause), 64'(e.cause));
          check_val("exc_epc", 64'(exc_epc), 64'(e.epc));
          check_val("exc_flush", 64'(flush), 64'(1));
        end
      end else begin
        check_val("idle_cause", 64'(exc_cause), 64'(0));
        check_val("idle_epc", 64'(exc_epc), 64'(0));
        if (!eret) check_val("idle_flush", 64'(flush), 64'(0));
        if (sb.size() != 0 && sb[0].at <= cyc) begin
          check_val("missed_exc_req", 64'(exc_req), 64'(1));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2 reset = 1'b0;
    #1;
    check_val("rst_exc_req", 64'(exc_req), 64'(0));
    check_val("rst_flush", 64'(flush), 64'(0));
    check_val("rst_cause", 64'(exc_cause), 64'(0));
    check_val("rst_epc", 64'(exc_epc), 64'(0));
    tick();
    tick();
    reset  = 1'b1;
    mon_en = 1'b1;
    drain(2);

    // Stage-0 RI hit, two cycles to commit.
    t = cyc;
    expect_exc(t + 3, 32'h0000_0028, 32'h3000);
    clr(); issue(32'h3000, 1'b0); tick();
    clr(); set_hit(0, 1, RI); tick();
    drain(4);

    // Older stage-0 AdEL beats later stage-1 Ov.
    t = cyc;
    expect_exc(t + 3, 32'h0000_0010, 32'h3100);
    clr(); issue(32'h3100, 1'b0); tick();
    clr(); set_hit(0, 0, ADEL); tick();
    clr(); set_hit(1, 2, OV); tick();
    drain(3);

    // Delay-slot instruction: BD set, EPC points at the branch.
    t = cyc;
    expect_exc(t + 3, 32'h8000_0030, 32'h3004);
    clr(); issue(32'h3008, 1'b1); tick();
    drain(2);
    clr(); set_hit(2, 0, OV); tick();
    drain(2);

    // Interrupt waits through commit-stage bubbles.
    clr(); int_req = 1'b1; tick();
    clr(); int_req = 1'b1; tick();
    t = cyc;
    expect_exc(t + 3, 32'h0000_0000, 32'h3200);
    clr(); int_req = 1'b1; issue(32'h3200, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      clr(); int_req = 1'b1; tick();
    end
    drain(2);

    // Stall stages 0-1 for three cycles; bubbles reach commit meanwhile.
    t = cyc;
    expect_exc(t + 6, 32'h0000_0014, 32'h3300);
    clr(); issue(32'h3300, 1'b0); tick();
    clr(); tick();
    for (int i = 0; i < 3; i++) begin
      clr(); stall = 3'b011; set_hit(1, 3, ADES); tick();
    end
    clr(); set_hit(1, 3, ADES); tick();
    drain(3);

    // Exception flush kills younger records and the same-cycle stage-0 load.
    t = cyc;
    expect_exc(t + 3, 32'h0000_0028, 32'h3600);
    clr(); issue(32'h3600, 1'b0); tick();
    clr(); issue(32'h3604, 1'b0); set_hit(0, 1, RI); tick();
    clr(); set_hit(0, 0, OV); tick();
    clr(); issue(32'h3608, 1'b0); tick();
    clr(); set_hit(0, 0, OV); tick();
    drain(4);

    // eret alone flushes a valid commit record and its younger neighbour.
    clr(); issue(32'h3400, 1'b0); tick();
    clr(); issue(32'h3404, 1'b0); tick();
    clr(); set_hit(0, 0, OV); tick();
    clr(); eret = 1'b1;
    #1;
    check_val("eret_flush", 64'(flush), 64'(1));
    check_val("eret_no_exc", 64'(exc_req), 64'(0));
    tick();
    drain(4);
    clr(); eret = 1'b1;
    #1;
    check_val("eret_bubble_flush", 64'(flush), 64'(0));
    tick();
    drain(1);

    // Exception and eret together: exception wins.
    t = cyc;
    expect_exc(t + 3, 32'h0000_0028, 32'h3500);
    clr(); issue(32'h3500, 1'b0); tick();
    drain(2);
    clr(); set_hit(2, 1, RI); eret = 1'b1;
    #1;
    check_val("exc_eret_flush", 64'(flush), 64'(1));
    tick();
    drain(2);

    // Asynchronous reset with a full pipeline.
    clr(); issue(32'h3700, 1'b0); tick();
    clr(); issue(32'h3704, 1'b0); tick();
    clr(); issue(32'h3708, 1'b0); tick();
    clr(); int_req = 1'b1; set_hit(2, 0, OV);
    #1;
    check_val("pre_reset_exc", 64'(exc_req), 64'(1));
    reset = 1'b0;
    #1;
    check_val("mid_rst_exc_req", 64'(exc_req), 64'(0));
    check_val("mid_rst_flush", 64'(flush), 64'(0));
    check_val("mid_rst_cause", 64'(exc_cause), 64'(0));
    check_val("mid_rst_epc", 64'(exc_epc), 64'(0));
    tick();
    // Release with a new instruction; int_req stays high to expose leftovers.
    clr(); int_req = 1'b1; reset = 1'b1; issue(32'h3800, 1'b0);
    t = cyc;
    expect_exc(t + 3, 32'h0000_0010, 32'h3800);
    tick();
    clr(); int_req = 1'b1; set_hit(0, 0, ADEL); tick();
    clr(); int_req = 1'b1; tick();
    clr(); int_req = 1'b1; tick();
    drain(4);

    check_val("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
